// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one access in flight at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of dm priority with a fetch starvation guard.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                clk_en,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e              state_q;
    logic                owner_dm_q;
    logic                mem_we_q;
    logic [BE_W-1:0]     mem_be_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic any_req;
    logic pick_if;

    assign any_req = if_req | dm_req;

`ifdef MEM_ARB_RR_EN
    // Resets to DM so the first contention goes to fetch.
    logic last_dm_q;

    always_comb begin
        pick_if = if_req && (!dm_req || last_dm_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dm_q <= 1'b1;
        end else if (clk_en && state_q == StIdle && any_req) begin
            last_dm_q <= !pick_if;
        end
    end
`else
    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q;

    always_comb begin
        pick_if = if_req && (!dm_req || wait_cnt_q == MaxWait);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (clk_en && state_q == StIdle && any_req) begin
            if (pick_if) begin
                wait_cnt_q <= '0;
            end else if (if_req && wait_cnt_q != MaxWait) begin
                wait_cnt_q <= wait_cnt_q + 4'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_dm_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (clk_en) begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        state_q    <= StReq;
                        owner_dm_q <= !pick_if;
                        if (pick_if) begin
                            mem_we_q    <= 1'b0;
                            mem_be_q    <= '1;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                        end else begin
                            mem_we_q    <= dm_we;
                            mem_be_q    <= dm_be;
                            mem_addr_q  <= dm_addr;
                            mem_wdata_q <= dm_wdata;
                        end
                    end
                end
                // A response arriving with the grant is not ours yet; only the grant counts.
                StReq: begin
                    if (mem_gnt) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (mem_rvalid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic gnt_ok;
    logic rsp_ok;

    always_comb begin
        busy      = (state_q != StIdle);
        mem_req   = clk_en && (state_q == StReq);
        mem_we    = mem_we_q;
        mem_be    = mem_be_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;

        gnt_ok    = mem_req && mem_gnt;
        rsp_ok    = clk_en && (state_q == StResp) && mem_rvalid;

        if_gnt    = gnt_ok && !owner_dm_q;
        dm_gnt    = gnt_ok && owner_dm_q;
        if_rvalid = rsp_ok && !owner_dm_q;
        dm_rvalid = rsp_ok && owner_dm_q;
        if_rdata  = mem_rdata;
        dm_rdata  = mem_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the round-robin scenario runs only when MEM_ARB_RR_EN is set.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        clk_en;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter dut (
        .clk(clk), .clk_en(clk_en), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b1;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick(); tick();
        #1;
        total++;
        if ({busy, mem_req, mem_we, if_gnt, dm_gnt, if_rvalid, dm_rvalid} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {busy, mem_req, mem_we, if_gnt, dm_gnt, if_rvalid, dm_rvalid});
        end
        total++;
        if ({mem_be, mem_addr, mem_wdata} !== 68'h0) begin
            bad++;
            $display("FAIL reset_payload: got %h want 0", {mem_be, mem_addr, mem_wdata});
        end
        rst = 1'b0; mem_gnt = 0; mem_rvalid = 0;
        tick();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        total++;
        if ({busy, mem_req} !== 2'b00) begin
            bad++; $display("FAIL fetch_idle: got %b want 00", {busy, mem_req});
        end
        tick();
        mem_gnt = 1'b1;
        #1;
        total++;
        if ({mem_req, mem_we, if_gnt, dm_gnt, mem_addr} !== {4'b1010, 32'h100}) begin
            bad++;
            $display("FAIL fetch_req: got %b/%h want 1010/00000100",
                     {mem_req, mem_we, if_gnt, dm_gnt}, mem_addr);
        end
        tick();
        if_req = 0; mem_gnt = 0; mem_rvalid = 1'b1; mem_rdata = 32'h13;
        #1;
        total++;
        if ({mem_req, busy, if_rvalid, dm_rvalid, if_rdata} !== {4'b0110, 32'h13}) begin
            bad++;
            $display("FAIL fetch_resp: got %b/%h want 0110/00000013",
                     {mem_req, busy, if_rvalid, dm_rvalid}, if_rdata);
        end
        tick();
        mem_rvalid = 0;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL fetch_done: busy got %b want 0", busy); end
    endtask

    task automatic test_contention();
        if_req = 1'b1; if_addr = 32'h104;
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
        tick();
        mem_gnt = 1'b1;
        #1;
        total++;
        if ({mem_we, mem_be, mem_addr, mem_wdata, dm_gnt, if_gnt} !==
            {1'b1, 4'hF, 32'h200, 32'hDEADBEEF, 2'b10}) begin
            bad++;
            $display("FAIL cont_store: got we=%b be=%h a=%h d=%h g=%b want 1/f/200/deadbeef/10",
                     mem_we, mem_be, mem_addr, mem_wdata, {dm_gnt, if_gnt});
        end
        tick();
        dm_req = 0; mem_gnt = 0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
        #1;
        total++;
        if ({dm_rvalid, if_rvalid} !== 2'b10) begin
            bad++; $display("FAIL cont_store_rsp: got %b want 10", {dm_rvalid, if_rvalid});
        end
        tick();
        mem_rvalid = 0;
        tick();
        mem_gnt = 1'b1;
        #1;
        total++;
        if ({mem_we, mem_addr, if_gnt, dm_gnt} !== {1'b0, 32'h104, 2'b10}) begin
            bad++;
            $display("FAIL cont_fetch: got we=%b a=%h g=%b want 0/104/10",
                     mem_we, mem_addr, {if_gnt, dm_gnt});
        end
        tick();
        if_req = 0; mem_gnt = 0; mem_rvalid = 1'b1; mem_rdata = 32'h55;
        #1;
        total++;
        if ({if_rvalid, dm_rvalid, if_rdata} !== {2'b10, 32'h55}) begin
            bad++;
            $display("FAIL cont_fetch_rsp: got %b/%h want 10/00000055", {if_rvalid, dm_rvalid}, if_rdata);
        end
        tick();
        mem_rvalid = 0;
    endtask

    task automatic test_starvation();
        logic exp_if;
        if_req = 1'b1; if_addr = 32'h400;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h500; dm_wdata = 0;
        for (int i = 0; i < 6; i++) begin
            exp_if = (i == 4);
            tick();
            mem_gnt = 1'b1;
            #1;
            total++;
            if ({if_gnt, dm_gnt} !== {exp_if, !exp_if}) begin
                bad++;
                $display("FAIL starve_gnt%0d: got %b want %b", i, {if_gnt, dm_gnt}, {exp_if, !exp_if});
            end
            tick();
            mem_gnt = 0; mem_rvalid = 1'b1;
            #1;
            total++;
            if ({if_rvalid, dm_rvalid} !== {exp_if, !exp_if}) begin
                bad++;
                $display("FAIL starve_rsp%0d: got %b want %b", i, {if_rvalid, dm_rvalid},
                         {exp_if, !exp_if});
            end
            tick();
            mem_rvalid = 0;
        end
        if_req = 0; dm_req = 0;
    endtask

    task automatic test_stalls();
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'h3; dm_addr = 32'h300; dm_wdata = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({mem_req, busy, dm_gnt, mem_be, mem_addr} !== {3'b110, 4'h3, 32'h300}) begin
                bad++;
                $display("FAIL stall_req%0d: got %b/%h/%h want 110/3/300", i,
                         {mem_req, busy, dm_gnt}, mem_be, mem_addr);
            end
            tick();
        end
        mem_gnt = 1'b1;
        #1;
        total++;
        if (dm_gnt !== 1'b1) begin bad++; $display("FAIL stall_gnt: got %b want 1", dm_gnt); end
        tick();
        dm_req = 0; mem_gnt = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({mem_req, busy, dm_rvalid} !== 3'b010) begin
                bad++;
                $display("FAIL stall_resp%0d: got %b want 010", i, {mem_req, busy, dm_rvalid});
            end
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0F0F;
        #1;
        total++;
        if ({busy, dm_rvalid, dm_rdata} !== {2'b11, 32'hA5A5_0F0F}) begin
            bad++;
            $display("FAIL stall_rvalid: got %b/%h want 11/a5a50f0f", {busy, dm_rvalid}, dm_rdata);
        end
        tick();
        mem_rvalid = 0;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL stall_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_reset_in_resp();
        if_req = 1'b1; if_addr = 32'h600;
        tick();
        mem_gnt = 1'b1;
        tick();
        if_req = 0; mem_gnt = 0; rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rstresp_pre: busy got %b want 1", busy); end
        tick();
        rst = 0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #1;
        total++;
        if ({busy, mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_addr} !== {6'b0, 32'h0}) begin
            bad++;
            $display("FAIL rstresp_stray: got %b/%h want 000000/0",
                     {busy, mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid}, mem_addr);
        end
        tick();
        mem_rvalid = 0;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rstresp_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_clk_en();
        if_req = 1'b1; if_addr = 32'h700;
        tick();
        clk_en = 0; mem_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if ({mem_req, if_gnt, dm_gnt, busy} !== 4'b0001) begin
                bad++;
                $display("FAIL clken_hold%0d: got %b want 0001", i, {mem_req, if_gnt, dm_gnt, busy});
            end
            tick();
        end
        // Response coinciding with the grant must be ignored.
        clk_en = 1'b1; mem_rvalid = 1'b1;
        #1;
        total++;
        if ({mem_req, if_gnt, if_rvalid, mem_addr} !== {3'b110, 32'h700}) begin
            bad++;
            $display("FAIL clken_gnt: got %b/%h want 110/700", {mem_req, if_gnt, if_rvalid}, mem_addr);
        end
        tick();
        if_req = 0; mem_gnt = 0; mem_rvalid = 0;
        #1;
        total++;
        if ({busy, if_rvalid} !== 2'b10) begin
            bad++; $display("FAIL clken_resp_wait: got %b want 10", {busy, if_rvalid});
        end
        tick();
        mem_rvalid = 1'b1;
        #1;
        total++;
        if (if_rvalid !== 1'b1) begin bad++; $display("FAIL clken_rsp: got %b want 1", if_rvalid); end
        tick();
        mem_rvalid = 0;
    endtask

`ifdef MEM_ARB_RR_EN
    task automatic test_round_robin();
        logic exp_if;
        rst = 1'b1;
        tick();
        rst = 0; if_req = 1'b1; if_addr = 32'h800; dm_req = 1'b1; dm_addr = 32'h900;
        for (int i = 0; i < 4; i++) begin
            exp_if = (i % 2 == 0);
            tick();
            mem_gnt = 1'b1;
            #1;
            total++;
            if ({if_gnt, dm_gnt} !== {exp_if, !exp_if}) begin
                bad++;
                $display("FAIL rr_gnt%0d: got %b want %b", i, {if_gnt, dm_gnt}, {exp_if, !exp_if});
            end
            tick();
            mem_gnt = 0; mem_rvalid = 1'b1;
            tick();
            mem_rvalid = 0;
        end
        if_req = 0; dm_req = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
`ifndef MEM_ARB_RR_EN
        test_starvation();
`endif
        test_stalls();
        test_reset_in_resp();
        test_clk_en();
`ifdef MEM_ARB_RR_EN
        test_round_robin();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
